// File: rtl/align_pkg.sv
// Shared types and sizing for the right-shift aligner.
// The payload struct is sized by ALIGN_N/ALIGN_SW. Retarget the mantissa width
// by changing ALIGN_N here; the aligner parameters default to these values.
// Optional feature macro: ALIGN_STICKY_EN (adds the sticky field to the payload).
package align_pkg;

  // Number of logarithmic shift levels for an n-bit word (n is a power of 2).
  function automatic int align_levels(input int n);
    return $clog2(n);
  endfunction

  localparam int ALIGN_N  = 16;
  localparam int ALIGN_L  = align_levels(ALIGN_N);
  localparam int ALIGN_SW = ALIGN_L + 1;

  // Inter-level payload: word, shift amount still to apply, sticky, slot valid.
  typedef struct packed {
    logic [ALIGN_N-1:0]  data;
    logic [ALIGN_SW-1:0] shamt;
`ifdef ALIGN_STICKY_EN
    logic                sticky;
`endif
    logic                valid;
  } align_payload_t;

endpackage

// File: rtl/align_rshift_stage.sv
// One level of the logarithmic right shifter: conditionally shifts by 2^K and
// registers the payload when the pipeline enable is high.
// Optional feature macro: ALIGN_STICKY_EN (ORs the dropped bits into sticky).
module align_rshift_stage
  import align_pkg::*;
#(
  parameter int N = ALIGN_N,
  parameter int K = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  align_payload_t d,
  output align_payload_t q
);

  localparam int SH = 1 << K;

  align_payload_t nxt;

  // Select between the word and the word shifted by 2^K; collect dropped bits.
  always_comb begin
    nxt = d;
    if (d.shamt[K]) begin
      nxt.data = d.data >> SH;
`ifdef ALIGN_STICKY_EN
      nxt.sticky = d.sticky | (|d.data[SH-1:0]);
`endif
    end
  end

  // Payload register; the whole pipeline holds together when en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/align_rshift_pipe.sv
// Pipelined logarithmic right-shift aligner for the FP adder alignment path.
// Shifts in_data right by in_shamt over log2(N) registered levels, with a
// valid/ready handshake and a single global stall enable.
// Optional feature macro: ALIGN_STICKY_EN (adds out_sticky and sticky tracking).
module align_rshift_pipe
  import align_pkg::*;
#(
  parameter int N  = ALIGN_N,
  parameter int SW = ALIGN_SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_shamt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data
`ifdef ALIGN_STICKY_EN
  ,
  output logic          out_sticky
`endif
);

  localparam int L = align_levels(N);

  align_payload_t pre;
  align_payload_t lvl [0:L];
  logic           en;

  // Shift amounts of N or more empty the word entirely; the low shift bits are
  // cleared so the levels pass the (zero) word through untouched.
  always_comb begin
    pre       = '0;
    pre.valid = in_valid;
    pre.data  = in_data;
    pre.shamt = in_shamt;
`ifdef ALIGN_STICKY_EN
    pre.sticky = 1'b0;
`endif
    if (|in_shamt[SW-1:L]) begin
      pre.data  = '0;
      pre.shamt = '0;
`ifdef ALIGN_STICKY_EN
      pre.sticky = |in_data;
`endif
    end
  end

  assign lvl[0] = pre;

  // Advance only when the output slot is empty or being consumed.
  always_comb begin
    en = !lvl[L].valid || out_ready;
  end

  assign in_ready = en;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    align_rshift_stage #(
      .N (N),
      .K (k)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (lvl[k]),
      .q   (lvl[k+1])
    );
  end

  assign out_valid = lvl[L].valid;
  assign out_data  = lvl[L].data;
`ifdef ALIGN_STICKY_EN
  assign out_sticky = lvl[L].sticky;
`endif

  // All shift bits are consumed by the last level; the residue is not needed.
  logic unused_shamt;
  assign unused_shamt = ^lvl[L].shamt;

endmodule

// File: tb/tb_align_rshift_pipe.sv
// Scoreboard bench for align_rshift_pipe (N=16, SW=5).
// Works with and without ALIGN_STICKY_EN; sticky is only checked when defined.
module tb_align_rshift_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef ALIGN_STICKY_EN
  logic        out_sticky;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] d;
    logic        s;
  } exp_t;

  exp_t sbq[$];

  align_rshift_pipe #(.N(16), .SW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_shamt   (in_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef ALIGN_STICKY_EN
    ,
    .out_sticky (out_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pop and compare whenever a result is transferred.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", out_data);
      end else begin
        e = sbq.pop_front();
        check("sb_data", {16'h0, out_data}, {16'h0, e.d});
`ifdef ALIGN_STICKY_EN
        check("sb_sticky", {31'h0, out_sticky}, {31'h0, e.s});
`endif
      end
    end
  end

  // Present one word and hold it until accepted; expected result queued on accept.
  task automatic send(input logic [15:0] d, input logic [4:0] s,
                      input logic [15:0] ed, input logic es);
    logic acc;
    int   n;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=%0d required=<50", n);
    end else begin
      e.d = ed;
      e.s = es;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send one word into an empty pipe and measure the acceptance-to-valid latency.
  task automatic single(input logic [15:0] d, input logic [4:0] s,
                        input logic [15:0] ed, input logic es);
    int n;
    send(d, s, ed, es);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, 4);
    idle(2);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", sbq.size(), 0);
  endtask

  logic [15:0] vd [9] = '{16'hA5C3, 16'h8001, 16'h8000, 16'h00F0, 16'h0000,
                          16'hFFFF, 16'h00FF, 16'hF00F, 16'h8000};
  logic [4:0]  vs [9] = '{5'd0, 5'd1, 5'd15, 5'd16, 5'd31, 5'd15, 5'd8, 5'd4, 5'd31};
  logic [15:0] ve [9] = '{16'hA5C3, 16'h4000, 16'h0001, 16'h0000, 16'h0000,
                          16'h0001, 16'h0000, 16'h0F00, 16'h0000};
  logic        vk [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  // 0x1234 shifted right by 0..5
  logic [15:0] bd [6] = '{16'h1234, 16'h091A, 16'h048D, 16'h0246, 16'h0123, 16'h0091};
  logic        bk [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hold_d;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_out_data", {16'h0, out_data}, 0);
    check("rst_in_ready", {31'h0, in_ready}, 1);
`ifdef ALIGN_STICKY_EN
    check("rst_out_sticky", {31'h0, out_sticky}, 0);
`endif

    for (int i = 0; i < 9; i++) begin
      single(vd[i], vs[i], ve[i], vk[i]);
    end
    drain();

    // Back-to-back with a three-cycle output stall.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(16'h1234, i[4:0], bd[i], bk[i]);
        end
        in_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("stall_wait_valid", {31'h0, out_valid}, 1);
        out_ready = 1'b0;
        hold_d = out_data;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", {31'h0, in_ready}, 0);
          check("stall_out_valid", {31'h0, out_valid}, 1);
          check("stall_hold_data", {16'h0, out_data}, {16'h0, hold_d});
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    idle(2);

    // Reset with three words in flight.
    send(16'hFFFF, 5'd1, 16'h7FFF, 1'b1);
    send(16'hAAAA, 5'd2, 16'h2AAA, 1'b1);
    send(16'h5555, 5'd3, 16'h0AAA, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", {31'h0, out_valid}, 0);
    idle(8);
    check("midrst_no_stale", {31'h0, out_valid}, 0);
    single(16'hC000, 5'd14, 16'h0003, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
